// File: rtl/cfg_chain_loader_if.sv
// Stream and configuration-chain signals of the chain loader.
// The slave modport is the loader's view, the master modport is the source/chain side.
interface cfg_chain_loader_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] prog_o;
  logic              prog_shft;
  logic [DATA_W-1:0] chain_i;

  modport master (
    output s_data, s_valid, chain_i,
    input  s_ready, prog_o, prog_shft
  );

  modport slave (
    input  s_data, s_valid, chain_i,
    output s_ready, prog_o, prog_shft
  );
endinterface

// File: rtl/cfg_chain_loader.sv
// Shifts CHAIN_LEN bitstream words into the tile configuration chain, then optionally
// recirculates the chain once and compares a rotate-XOR readback signature.
module cfg_chain_loader #(
  parameter int DATA_W    = 32,
  parameter int CHAIN_LEN = 72
) (
  input  logic              clk,
  input  logic              nres,
  input  logic              start,
  input  logic              verify_en,
  cfg_chain_loader_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] signature
);
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, VERIFY, CHECK} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic [DATA_W-1:0] sig_ld_q, sig_ld_d;
  logic [DATA_W-1:0] sig_rb_q, sig_rb_d;
  logic [DATA_W-1:0] sig_out_q, sig_out_d;
  logic              verify_q, verify_d;
  logic              shft_q, shft_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  function automatic logic [DATA_W-1:0] rot_xor(input logic [DATA_W-1:0] s,
                                                input logic [DATA_W-1:0] w);
    return {s[DATA_W-2:0], s[DATA_W-1]} ^ w;
  endfunction

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      load_q    <= '0;
      sig_ld_q  <= '0;
      sig_rb_q  <= '0;
      sig_out_q <= '0;
      verify_q  <= 1'b0;
      shft_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      load_q    <= load_d;
      sig_ld_q  <= sig_ld_d;
      sig_rb_q  <= sig_rb_d;
      sig_out_q <= sig_out_d;
      verify_q  <= verify_d;
      shft_q    <= shft_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_d      = load_q;
    sig_ld_d    = sig_ld_q;
    sig_rb_d    = sig_rb_q;
    sig_out_d   = sig_out_q;
    verify_d    = verify_q;
    shft_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;
    bus.s_ready = 1'b0;
    bus.prog_o  = load_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          verify_d = verify_en;
          cnt_d    = '0;
          sig_ld_d = '0;
          sig_rb_d = '0;
          err_d    = 1'b0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        bus.s_ready = (cnt_q < LEN);
        // prog_shft is the registered beat, so the chain shifts one cycle after acceptance
        if (bus.s_valid && bus.s_ready) begin
          load_d   = bus.s_data;
          shft_d   = 1'b1;
          cnt_d    = cnt_q + ONE;
          sig_ld_d = rot_xor(sig_ld_q, bus.s_data);
          if (cnt_q + ONE == LEN) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (verify_q) begin
          cnt_d   = '0;
          shft_d  = 1'b1;
          state_d = VERIFY;
        end else begin
          state_d = CHECK;
        end
      end
      VERIFY: begin
        // Tail feeds straight back into the head; a full rotation restores the chain
        bus.prog_o = bus.chain_i;
        sig_rb_d   = rot_xor(sig_rb_q, bus.chain_i);
        cnt_d      = cnt_q + ONE;
        if (cnt_q + ONE == LEN) state_d = CHECK;
        else                    shft_d  = 1'b1;
      end
      CHECK: begin
        done_d    = 1'b1;
        sig_out_d = sig_ld_q;
        err_d     = verify_q && (sig_rb_q != sig_ld_q);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.prog_shft = shft_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign signature     = sig_out_q;
endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: behavioural chain model on the prog/chain ports,
// scenario tasks with inline comparisons against expectations derived from the word lists.
module tb_cfg_chain_loader;
  localparam int DW = 32;
  localparam int CL = 4;
  typedef logic [DW-1:0] word_t;

  logic  clk = 1'b0;
  logic  nres, start, verify_en, busy, done, err;
  word_t signature;

  cfg_chain_loader_if #(.DATA_W(DW)) bus ();

  cfg_chain_loader #(.DATA_W(DW), .CHAIN_LEN(CL)) dut (
    .clk       (clk),
    .nres      (nres),
    .start     (start),
    .verify_en (verify_en),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .signature (signature)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    tot_sh   = 0;
  int    sh_base  = 0;
  int    done_cnt = 0;
  bit    inject   = 1'b0;
  word_t chain_q [CL] = '{default: '0};
  word_t shlog [$];
  logic  shft_s = 1'b0;
  word_t po_s   = '0;

  // Tail of the modelled chain, optionally with bit 0 stuck high on the 2nd readback word
  assign bus.chain_i = chain_q[CL-1] | word_t'(inject && (tot_sh - sh_base == CL + 1));

  always @(negedge clk) begin
    shft_s = bus.prog_shft;
    po_s   = bus.prog_o;
    if (done === 1'b1) done_cnt++;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (shft_s === 1'b1 && nres === 1'b1) begin
      for (int i = CL - 1; i > 0; i--) chain_q[i] <= chain_q[i-1];
      chain_q[0] <= po_s;
      shlog.push_back(po_s);
      tot_sh <= tot_sh + 1;
    end
  end

  task automatic run_txn(input string tag, input word_t w [CL], input int gap,
                         input bit ver, input bit inj, input bit poke);
    int    beat_cyc, done_cyc, d0, t, nsh;
    word_t exp_sig, exp_w;
    exp_sig = '0;
    for (int i = 0; i < CL; i++) exp_sig = {exp_sig[DW-2:0], exp_sig[DW-1]} ^ w[i];
    sh_base  = tot_sh;
    inject   = inj;
    d0       = done_cnt;
    beat_cyc = 0;

    @(negedge clk);
    start = 1'b1; verify_en = ver; bus.s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; verify_en = 1'($urandom_range(0, 1));
    n_checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start_accept: busy=%b err=%b, required busy=1 err=0", tag, busy, err);
    end

    for (int i = 0; i < CL; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          bus.s_valid = 1'b0; bus.s_data = $urandom;
          if (g > 0) begin
            n_checks++;
            if (bus.prog_shft !== 1'b0) begin
              n_fail++;
              $display("FAIL %s bubble_shft: got %b, required 0", tag, bus.prog_shft);
            end
          end
          @(negedge clk);
        end
      end
      bus.s_valid = 1'b1; bus.s_data = w[i];
      if (poke && i == 1) begin start = 1'b1; verify_en = !ver; end
      t = 0;
      while (bus.s_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin
        n_fail++;
        $display("FAIL %s ready_timeout: beat %0d never accepted", tag, i);
      end
      beat_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
    end

    bus.s_data = $urandom;
    n_checks++;
    if (bus.s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ready_after_full: got %b, required 0", tag, bus.s_ready);
    end

    t = 0;
    while (done !== 1'b1 && t < 200) begin
      start = poke && ver && (tot_sh - sh_base == CL + 1);
      @(negedge clk); t++;
    end
    start    = 1'b0;
    done_cyc = cyc;
    n_checks++;
    if (done_cyc != beat_cyc + 3 + (ver ? CL : 0)) begin
      n_fail++;
      $display("FAIL %s done_latency: got %0d cycles after last beat, required %0d",
               tag, done_cyc - beat_cyc, 3 + (ver ? CL : 0));
    end
    bus.s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL %s done_pulse: pulses=%0d done=%b, required 1 pulse then 0",
               tag, done_cnt - d0, done);
    end

    nsh = tot_sh - sh_base;
    n_checks++;
    if (nsh != (ver ? 2 * CL : CL)) begin
      n_fail++;
      $display("FAIL %s shift_count: got %0d, required %0d", tag, nsh, ver ? 2 * CL : CL);
    end
    for (int i = 0; i < CL; i++) begin
      n_checks++;
      if (i >= nsh || shlog[sh_base+i] !== w[i]) begin
        n_fail++;
        $display("FAIL %s load_word%0d: got %h, required %h", tag, i,
                 (i < nsh) ? shlog[sh_base+i] : 'x, w[i]);
      end
    end
    for (int i = 0; i < CL; i++) begin
      exp_w = w[i] | word_t'(inj && i == 1);
      if (ver) begin
        n_checks++;
        if (CL + i >= nsh || shlog[sh_base+CL+i] !== exp_w) begin
          n_fail++;
          $display("FAIL %s readback_word%0d: got %h, required %h", tag, i,
                   (CL + i < nsh) ? shlog[sh_base+CL+i] : 'x, exp_w);
        end
      end
      n_checks++;
      if (chain_q[CL-1-i] !== (ver ? exp_w : w[i])) begin
        n_fail++;
        $display("FAIL %s chain_word%0d: got %h, required %h", tag, i,
                 chain_q[CL-1-i], ver ? exp_w : w[i]);
      end
    end
    n_checks++;
    if (signature !== exp_sig) begin
      n_fail++;
      $display("FAIL %s signature: got %h, required %h", tag, signature, exp_sig);
    end
    n_checks++;
    if (err !== inj || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s err_busy: err=%b busy=%b, required err=%b busy=0", tag, err, busy, inj);
    end
    inject = 1'b0;
  endtask

  task automatic fixed_words(output word_t w [CL]);
    for (int i = 0; i < CL; i++) w[i] = word_t'(32'h1111_1111 * (i + 1));
  endtask

  task automatic rand_words(output word_t w [CL]);
    for (int i = 0; i < CL; i++) w[i] = $urandom;
  endtask

  task automatic test_reset();
    nres = 1'b1; start = 1'b0; verify_en = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
    #2 nres = 1'b0;
    #1;
    n_checks++;
    if ({bus.s_ready, bus.prog_shft, busy, done, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready/shft/busy/done/err=%b, required 00000",
               {bus.s_ready, bus.prog_shft, busy, done, err});
    end
    n_checks++;
    if (bus.prog_o !== '0 || signature !== '0) begin
      n_fail++;
      $display("FAIL reset_data: prog_o=%h signature=%h, required 0", bus.prog_o, signature);
    end
    repeat (2) @(negedge clk);
    nres = 1'b1;
    // Source asserting valid while idle must be ignored
    bus.s_valid = 1'b1; bus.s_data = $urandom;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (bus.s_ready !== 1'b0 || bus.prog_shft !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_valid: ready=%b shft=%b busy=%b, required 000",
                 bus.s_ready, bus.prog_shft, busy);
      end
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic test_load_b2b();
    word_t w [CL];
    fixed_words(w);
    run_txn("load_b2b", w, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_load_bubbles();
    word_t w [CL];
    fixed_words(w);
    run_txn("load_bubbles", w, 2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_verify();
    word_t w [CL];
    rand_words(w);
    run_txn("verify", w, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_verify_fault();
    word_t w [CL];
    fixed_words(w);
    run_txn("verify_fault", w, 1, 1'b1, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b, required 1", err);
    end
    rand_words(w);
    run_txn("after_fault", w, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midload();
    word_t w [CL];
    int    d0;
    d0 = done_cnt;
    @(negedge clk); start = 1'b1; verify_en = 1'b0;
    @(negedge clk); start = 1'b0; bus.s_valid = 1'b1; bus.s_data = $urandom;
    @(negedge clk); bus.s_data = $urandom;
    @(negedge clk); bus.s_valid = 1'b0; nres = 1'b0;
    #1;
    n_checks++;
    if (bus.s_ready !== 1'b0 || bus.prog_shft !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midload_reset: ready=%b shft=%b busy=%b, required 000",
               bus.s_ready, bus.prog_shft, busy);
    end
    repeat (2) @(negedge clk);
    nres = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt != d0 || signature !== '0) begin
      n_fail++;
      $display("FAIL midload_no_done: pulses=%0d signature=%h, required 0 and 0",
               done_cnt - d0, signature);
    end
    rand_words(w);
    run_txn("after_reset", w, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    word_t w [CL];
    rand_words(w);
    run_txn("start_busy", w, 1, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    word_t w [CL];
    for (int n = 0; n < 6; n++) begin
      rand_words(w);
      run_txn($sformatf("random%0d", n), w, $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_load_b2b();
    test_load_bubbles();
    test_verify();
    test_verify_fault();
    test_reset_midload();
    test_start_while_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
